// File: rtl/oled_page_writer_if.sv
// Byte-transfer and framebuffer bus used by oled_page_writer.
//   fb_addr      : framebuffer read address (driven by the writer)
//   fb_rdata     : framebuffer read data, valid one cycle after fb_addr
//   i2c_reg_addr : control byte for the i2c_master (0x00 command, 0x40 data)
//   i2c_data     : payload byte for the i2c_master
//   i2c_enable   : byte-transfer request
//   i2c_done     : one-cycle pulse, current byte transferred
// modport master : the page writer side
// modport slave  : the i2c_master / framebuffer side
interface oled_page_writer_if #(
  parameter int FB_AW = 9
);
  logic [FB_AW-1:0] fb_addr;
  logic [7:0]       fb_rdata;
  logic [7:0]       i2c_reg_addr;
  logic [7:0]       i2c_data;
  logic             i2c_enable;
  logic             i2c_done;

  modport master (
    output fb_addr, i2c_reg_addr, i2c_data, i2c_enable,
    input  fb_rdata, i2c_done
  );

  modport slave (
    input  fb_addr, i2c_reg_addr, i2c_data, i2c_enable,
    output fb_rdata, i2c_done
  );
endinterface

// File: rtl/oled_page_writer.sv
// Pushes a framebuffer to an OLED panel in page-addressing mode once the
// init sequencer has finished. For every page it sends three command bytes
// (page select, low column, high column) followed by COLS data bytes read
// from an external synchronous-read framebuffer RAM.
// Ports:
//   clk_32M    : system clock
//   rst        : asynchronous active-high reset
//   init_done  : level, init sequencer finished (refresh gated by it)
//   refresh    : one-cycle start-frame request (queued once while busy)
//   bus        : framebuffer read port + byte handshake to i2c_master
//   busy       : high from frame start until frame_done
//   frame_done : one-cycle pulse after the last byte of the frame
module oled_page_writer #(
  parameter int COLS  = 128,
  parameter int PAGES = 4,
  parameter int FB_AW = 9
) (
  input  logic                   clk_32M,
  input  logic                   rst,
  input  logic                   init_done,
  input  logic                   refresh,
  oled_page_writer_if.master     bus,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [PW-1:0] LAST_PAGE = PW'(PAGES - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);

  typedef enum logic [2:0] {
    IDLE, CMD_LOAD, CMD_SEND, FETCH, DAT_LOAD, DAT_SEND, FIN
  } state_t;

  state_t        state_reg;
  logic [PW-1:0] page_reg;
  logic [CW-1:0] col_reg;
  logic [1:0]    cmd_idx_reg;
  logic          pending_reg;
  logic [7:0]    cmd_byte;
  logic          byte_done;

  // Column start address is always 0, so the column commands are constant.
  always_comb begin
    cmd_byte = 8'h00;
    case (cmd_idx_reg)
      2'd0:    cmd_byte = 8'hB0 | 8'(page_reg);
      2'd1:    cmd_byte = 8'h00;
      default: cmd_byte = 8'h10;
    endcase
  end

  // A done pulse only counts while a transfer is actually being requested.
  assign byte_done = bus.i2c_done && bus.i2c_enable;

  function automatic logic [FB_AW-1:0] fb_index(input logic [PW-1:0] p,
                                                input logic [CW-1:0] c);
    return FB_AW'(int'(p) * COLS + int'(c));
  endfunction

  always_ff @(posedge clk_32M or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      page_reg         <= '0;
      col_reg          <= '0;
      cmd_idx_reg      <= '0;
      pending_reg      <= 1'b0;
      bus.fb_addr      <= '0;
      bus.i2c_reg_addr <= 8'h00;
      bus.i2c_data     <= 8'h00;
      bus.i2c_enable   <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Requests arriving mid-frame collapse into a single queued frame.
      if (refresh && state_reg != IDLE) begin
        pending_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (init_done && (refresh || pending_reg)) begin
            page_reg    <= '0;
            cmd_idx_reg <= '0;
            busy        <= 1'b1;
            pending_reg <= 1'b0;
            state_reg   <= CMD_LOAD;
          end
        end

        CMD_LOAD: begin
          bus.i2c_reg_addr <= 8'h00;
          bus.i2c_data     <= cmd_byte;
          bus.i2c_enable   <= 1'b1;
          state_reg        <= CMD_SEND;
        end

        CMD_SEND: begin
          if (byte_done) begin
            bus.i2c_enable <= 1'b0;
            if (cmd_idx_reg != 2'd2) begin
              cmd_idx_reg <= cmd_idx_reg + 2'd1;
              state_reg   <= CMD_LOAD;
            end else begin
              col_reg     <= '0;
              // Address is presented during FETCH so the RAM output is
              // ready to capture in DAT_LOAD.
              bus.fb_addr <= fb_index(page_reg, '0);
              state_reg   <= FETCH;
            end
          end
        end

        FETCH: begin
          state_reg <= DAT_LOAD;
        end

        DAT_LOAD: begin
          bus.i2c_data     <= bus.fb_rdata;
          bus.i2c_reg_addr <= 8'h40;
          bus.i2c_enable   <= 1'b1;
          state_reg        <= DAT_SEND;
        end

        DAT_SEND: begin
          if (byte_done) begin
            bus.i2c_enable <= 1'b0;
            if (col_reg != LAST_COL) begin
              col_reg     <= col_reg + 1'b1;
              bus.fb_addr <= fb_index(page_reg, col_reg + 1'b1);
              state_reg   <= FETCH;
            end else if (page_reg != LAST_PAGE) begin
              page_reg    <= page_reg + 1'b1;
              cmd_idx_reg <= '0;
              state_reg   <= CMD_LOAD;
            end else begin
              frame_done  <= 1'b1;
              busy        <= 1'b0;
              state_reg   <= FIN;
            end
          end
        end

        FIN: begin
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_page_writer.sv
// Directed testbench for oled_page_writer: reset, init_done gating, full
// frame contents, queued refresh, handshake robustness and mid-frame reset.
module tb_oled_page_writer;

  logic clk_32M = 1'b0;
  logic rst = 1'b1;
  logic init_done = 1'b0;
  logic refresh = 1'b0;
  logic busy;
  logic frame_done;

  oled_page_writer_if #(.FB_AW(9)) bus ();

  oled_page_writer #(.COLS(128), .PAGES(4), .FB_AW(9)) dut (
    .clk_32M    (clk_32M),
    .rst        (rst),
    .init_done  (init_done),
    .refresh    (refresh),
    .bus        (bus.master),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk_32M = ~clk_32M;

  // Framebuffer model: fb[i] = i[7:0], registered read.
  logic [7:0] fb_mem [512];
  initial for (int i = 0; i < 512; i++) fb_mem[i] = 8'(i);
  always @(posedge clk_32M) bus.fb_rdata <= fb_mem[bus.fb_addr];

  // i2c_master stand-in: done pulse after 5 cycles of enable; optional
  // spurious done whenever enable is low.
  logic resp_en = 1'b0, spur_en = 1'b0;
  logic resp_done = 1'b0, spur_done = 1'b0;
  int   rcnt = 0;
  assign bus.i2c_done = resp_done | spur_done;

  always @(negedge clk_32M) begin
    spur_done = spur_en && !bus.i2c_enable;
    if (!resp_en || resp_done) begin
      resp_done = 1'b0;
      rcnt = 0;
    end else if (bus.i2c_enable) begin
      rcnt++;
      if (rcnt == 5) resp_done = 1'b1;
    end else begin
      rcnt = 0;
    end
  end

  // Transfer log: one entry per accepted byte.
  logic [7:0] log_ra[$];
  logic [7:0] log_d[$];
  logic [8:0] log_fa[$];
  always @(posedge clk_32M) begin
    if (!rst && bus.i2c_enable && bus.i2c_done) begin
      log_ra.push_back(bus.i2c_reg_addr);
      log_d.push_back(bus.i2c_data);
      log_fa.push_back(bus.fb_addr);
    end
  end

  // frame_done pulse counting and payload stability while enable is high.
  int fd_cnt = 0, fd_busy_bad = 0, stable_err = 0;
  logic prev_en = 1'b0;
  logic [7:0] prev_ra = 8'h00, prev_d = 8'h00;
  always @(negedge clk_32M) begin
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (frame_done) begin
        fd_cnt++;
        if (busy) fd_busy_bad++;
      end
      if (prev_en && bus.i2c_enable &&
          (bus.i2c_data != prev_d || bus.i2c_reg_addr != prev_ra))
        stable_err++;
      prev_en = bus.i2c_enable;
      prev_ra = bus.i2c_reg_addr;
      prev_d  = bus.i2c_data;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_refresh();
    @(negedge clk_32M) refresh = 1'b1;
    @(negedge clk_32M) refresh = 1'b0;
  endtask

  task automatic clear_logs();
    log_ra.delete();
    log_d.delete();
    log_fa.delete();
    fd_cnt = 0;
    fd_busy_bad = 0;
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 30000 && fd_cnt < target; i++) @(posedge clk_32M);
    check("frame_wait", 32'(fd_cnt >= target), 32'd1);
  endtask

  // Compares one whole frame in the log starting at 'off' with the
  // expected page-mode byte sequence.
  task automatic verify_frame(input int off, output int bad);
    int idx;
    bad = 0;
    if (log_d.size() < off + 524) begin
      bad = 1;
      return;
    end
    for (int p = 0; p < 4; p++) begin
      idx = off + p * 131;
      if (log_ra[idx] != 8'h00 || log_d[idx] != (8'hB0 | 8'(p))) bad++;
      if (log_ra[idx+1] != 8'h00 || log_d[idx+1] != 8'h00) bad++;
      if (log_ra[idx+2] != 8'h00 || log_d[idx+2] != 8'h10) bad++;
      for (int c = 0; c < 128; c++) begin
        if (log_ra[idx+3+c] != 8'h40 || log_d[idx+3+c] != 8'(p * 128 + c))
          bad++;
      end
    end
  endtask

  initial begin
    int bad;
    int en_cnt;
    int viol;
    logic [7:0] d0;

    // ---- reset values ----
    repeat (3) @(posedge clk_32M);
    @(negedge clk_32M) rst = 1'b0;
    @(negedge clk_32M);
    check("rst_enable", 32'(bus.i2c_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
    check("rst_reg_addr", 32'(bus.i2c_reg_addr), 32'h00);
    check("rst_data", 32'(bus.i2c_data), 32'h00);

    // ---- refresh dropped while init_done=0 ----
    pulse_refresh();
    en_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_32M);
      if (bus.i2c_enable || busy) en_cnt++;
    end
    check("gate_no_enable", 32'(en_cnt), 32'd0);
    init_done = 1'b1;
    repeat (20) @(negedge clk_32M);
    check("gate_not_pending", 32'(busy), 32'd0);

    // ---- first frame with latency and content checks ----
    resp_en = 1'b1;
    clear_logs();
    @(negedge clk_32M) refresh = 1'b1;
    @(posedge clk_32M);
    @(negedge clk_32M) refresh = 1'b0;
    check("lat_t1_enable", 32'(bus.i2c_enable), 32'd0);
    check("lat_t1_busy", 32'(busy), 32'd1);
    @(negedge clk_32M);
    check("lat_t2_enable", 32'(bus.i2c_enable), 32'd1);
    check("lat_t2_data", 32'(bus.i2c_data), 32'hB0);
    wait_frames(1);
    repeat (20) @(negedge clk_32M);
    check("frame_len", 32'(log_d.size()), 32'd524);
    if (log_d.size() >= 4) begin
      check("first_ra0", 32'(log_ra[0]), 32'h00);
      check("first_d0", 32'(log_d[0]), 32'hB0);
      check("first_d1", 32'(log_d[1]), 32'h00);
      check("first_d2", 32'(log_d[2]), 32'h10);
      check("first_ra3", 32'(log_ra[3]), 32'h40);
      check("first_d3", 32'(log_d[3]), 32'h00);
    end else begin
      check("first_present", 32'(log_d.size()), 32'd4);
    end
    if (log_d.size() == 524) begin
      check("page3_cmd", 32'(log_d[393]), 32'hB3);
      check("last_ra", 32'(log_ra[523]), 32'h40);
      check("last_data", 32'(log_d[523]), 32'hFF);
      check("last_fb_addr", 32'(log_fa[523]), 32'd511);
    end
    verify_frame(0, bad);
    check("frame_content", 32'(bad), 32'd0);
    check("frame_done_count", 32'(fd_cnt), 32'd1);
    check("busy_low_at_done", 32'(fd_busy_bad), 32'd0);
    check("busy_after_frame", 32'(busy), 32'd0);
    check("payload_stable", 32'(stable_err), 32'd0);

    // ---- refresh while busy queues exactly one frame ----
    clear_logs();
    pulse_refresh();
    repeat (50) @(negedge clk_32M);
    pulse_refresh();
    repeat (300) @(negedge clk_32M);
    pulse_refresh();
    wait_frames(2);
    repeat (300) @(negedge clk_32M);
    check("pend_frames", 32'(fd_cnt), 32'd2);
    check("pend_len", 32'(log_d.size()), 32'd1048);
    verify_frame(0, bad);
    check("pend_frame0", 32'(bad), 32'd0);
    verify_frame(524, bad);
    check("pend_frame1", 32'(bad), 32'd0);
    check("pend_idle", 32'(busy), 32'd0);

    // ---- spurious i2c_done while enable is low ----
    clear_logs();
    spur_en = 1'b1;
    pulse_refresh();
    wait_frames(1);
    repeat (20) @(negedge clk_32M);
    spur_en = 1'b0;
    check("spur_len", 32'(log_d.size()), 32'd524);
    verify_frame(0, bad);
    check("spur_content", 32'(bad), 32'd0);

    // ---- stalled i2c_done: enable and payload held ----
    resp_en = 1'b0;
    clear_logs();
    pulse_refresh();
    for (int i = 0; i < 50 && !bus.i2c_enable; i++) @(negedge clk_32M);
    check("stall_enable_up", 32'(bus.i2c_enable), 32'd1);
    d0 = bus.i2c_data;
    check("stall_data", 32'(d0), 32'hB0);
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_32M);
      if (!bus.i2c_enable || bus.i2c_data != d0) viol++;
    end
    check("stall_hold", 32'(viol), 32'd0);

    // ---- reset during page 2 data ----
    resp_en = 1'b1;
    for (int i = 0; i < 5000 && log_d.size() < 275; i++) @(posedge clk_32M);
    check("reach_page2", 32'(log_d.size() >= 275), 32'd1);
    @(negedge clk_32M) rst = 1'b1;
    #1;
    check("arst_enable", 32'(bus.i2c_enable), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_frame_done", 32'(frame_done), 32'd0);
    check("arst_fb_addr", 32'(bus.fb_addr), 32'd0);
    pulse_refresh();
    repeat (3) @(negedge clk_32M);
    check("arst_hold_enable", 32'(bus.i2c_enable), 32'd0);
    check("arst_hold_busy", 32'(busy), 32'd0);
    check("arst_hold_fb_addr", 32'(bus.fb_addr), 32'd0);
    @(negedge clk_32M) rst = 1'b0;
    repeat (10) @(negedge clk_32M);
    check("arst_no_pending", 32'(busy), 32'd0);
    clear_logs();
    pulse_refresh();
    for (int i = 0; i < 500 && log_d.size() < 4; i++) @(posedge clk_32M);
    if (log_d.size() >= 4) begin
      check("restart_ra0", 32'(log_ra[0]), 32'h00);
      check("restart_d0", 32'(log_d[0]), 32'hB0);
      check("restart_ra3", 32'(log_ra[3]), 32'h40);
      check("restart_fb_addr", 32'(log_fa[3]), 32'd0);
      check("restart_d3", 32'(log_d[3]), 32'h00);
    end else begin
      check("restart_present", 32'(log_d.size()), 32'd4);
    end
    wait_frames(1);
    repeat (20) @(negedge clk_32M);
    verify_frame(0, bad);
    check("restart_frame", 32'(bad), 32'd0);
    check("payload_stable_end", 32'(stable_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
